// File: rtl/fir_param_if.sv
// Streaming sample/result handshake plus coefficient programming port for fir_param.
interface fir_param_if #(
    parameter int NUM_TAPS = 15,
    parameter int DATA_W   = 32,
    parameter int COEFF_W  = 8,
    parameter int OUT_W    = 32
);
    localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    logic                      clear;
    logic signed [DATA_W-1:0]  in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [OUT_W-1:0]   out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_sat;
    logic                      coeff_wr_en;
    logic [AW-1:0]             coeff_wr_addr;
    logic [COEFF_W-1:0]        coeff_wr_data;
    logic                      coeff_commit;

    modport master (
        output clear, in_data, in_valid, out_ready,
               coeff_wr_en, coeff_wr_addr, coeff_wr_data, coeff_commit,
        input  in_ready, out_data, out_valid, out_sat
    );

    modport slave (
        input  clear, in_data, in_valid, out_ready,
               coeff_wr_en, coeff_wr_addr, coeff_wr_data, coeff_commit,
        output in_ready, out_data, out_valid, out_sat
    );
endinterface

// File: rtl/fir_param.sv
// Direct-form FIR with double-buffered coefficients, warm-up suppression,
// decimation, rounding shift and output saturation behind a ready/valid stage.
module fir_param_tap #(
    parameter int DATA_W  = 32,
    parameter int COEFF_W = 8
) (
    input  logic signed [DATA_W-1:0]         i_x,
    input  logic signed [COEFF_W-1:0]        i_c,
    output logic signed [DATA_W+COEFF_W-1:0] o_p
);
    assign o_p = i_x * i_c;
endmodule

module fir_param #(
    parameter int NUM_TAPS = 15,
    parameter int DATA_W   = 32,
    parameter int COEFF_W  = 8,
    parameter int OUT_W    = 32,
    parameter int SHIFT    = 0,
    parameter int DECIM    = 1
) (
    input  logic        clk,
    input  logic        rst,
    fir_param_if.slave  bus
);
    localparam int AW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int PW    = DATA_W + COEFF_W;
    localparam int SUM_W = PW + $clog2(NUM_TAPS);
    localparam int EW    = SUM_W + 1;
    localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [NUM_TAPS-1:0][COEFF_W-1:0] r_shadow, r_coef;
    logic [NUM_TAPS-2:0][DATA_W-1:0]  r_hist;
    logic [AW-1:0]                    r_warm;
    logic [DW-1:0]                    r_phase;
    logic                             r_out_valid, r_out_sat;
    logic signed [OUT_W-1:0]          r_out_data;

    logic [NUM_TAPS-1:0][DATA_W-1:0]  w_x;
    logic [NUM_TAPS-1:0][PW-1:0]      w_prod;
    logic signed [SUM_W-1:0]          w_sum;
    logic signed [EW-1:0]             w_ext, w_shr;
    logic signed [OUT_W-1:0]          w_q;
    logic                             w_sat, w_in_ready, w_accept, w_warm_done, w_produce;

    // Tap 0 multiplies the sample being accepted; tap k uses the k-th older sample.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        if (k == 0) begin : g_cur
            assign w_x[k] = bus.in_data;
        end else begin : g_old
            assign w_x[k] = r_hist[k-1];
        end
        fir_param_tap #(.DATA_W(DATA_W), .COEFF_W(COEFF_W)) u_tap (
            .i_x ($signed(w_x[k])),
            .i_c ($signed(r_coef[k])),
            .o_p (w_prod[k])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) w_sum += SUM_W'($signed(w_prod[k]));
    end

    assign w_ext = {w_sum[SUM_W-1], w_sum};

    if (SHIFT > 0) begin : g_rnd
        logic signed [EW-1:0] w_rnd;
        assign w_rnd = w_ext + (EW'(1) <<< (SHIFT-1));
        assign w_shr = w_rnd >>> SHIFT;
    end else begin : g_nornd
        assign w_shr = w_ext;
    end

    always_comb begin
        w_sat = 1'b0;
        w_q   = w_shr[OUT_W-1:0];
        if (w_shr > MAXV) begin
            w_sat = 1'b1;
            w_q   = MAXV[OUT_W-1:0];
        end else if (w_shr < MINV) begin
            w_sat = 1'b1;
            w_q   = MINV[OUT_W-1:0];
        end
    end

    assign w_in_ready  = !rst && !bus.clear && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_warm_done = (r_warm == AW'(NUM_TAPS-1));
    assign w_produce   = w_accept && w_warm_done && (r_phase == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist      <= '0;
            r_warm      <= '0;
            r_phase     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (bus.clear) begin
            r_hist      <= '0;
            r_warm      <= '0;
            r_phase     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hist[0] <= bus.in_data;
                for (int k = 1; k < NUM_TAPS-1; k++) r_hist[k] <= r_hist[k-1];
                if (!w_warm_done)
                    r_warm <= r_warm + AW'(1);
                else
                    r_phase <= (r_phase == DW'(DECIM-1)) ? '0 : r_phase + DW'(1);
            end
            if (w_produce) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_q;
                r_out_sat   <= w_sat;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Commit copies the pre-edge shadow, so a same-cycle write only reaches the shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= '0;
            r_shadow[0] <= COEFF_W'(1);
            r_coef      <= '0;
            r_coef[0]   <= COEFF_W'(1);
        end else begin
            if (bus.coeff_wr_en && (int'(bus.coeff_wr_addr) < NUM_TAPS))
                r_shadow[bus.coeff_wr_addr] <= bus.coeff_wr_data;
            if (bus.coeff_commit)
                r_coef <= r_shadow;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
endmodule

// File: doc/fir_param.md
FIR_PARAM -- requirements
Module: fir_param

Interface
REQ-001 Parameter NUM_TAPS, default 15, number of filter taps (>=2).
REQ-002 Parameter DATA_W, default 32, signed input sample width.
REQ-003 Parameter COEFF_W, default 8, signed coefficient width.
REQ-004 Parameter OUT_W, default 32, signed output width (<= full-precision width).
REQ-005 Parameter SHIFT, default 0, right-shift applied to the full-precision sum before output.
REQ-006 Parameter DECIM, default 1, decimation factor (>=1).
REQ-007 clk  input  1  clock; all logic on the rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 clear  input  1  synchronous flush of sample history, warm-up and decimation state.
REQ-010 in_data  input  DATA_W  signed sample.
REQ-011 in_valid  input  1  in_data is present.
REQ-012 in_ready  output  1  block accepts a sample this cycle.
REQ-013 out_data  output  OUT_W  signed filtered result.
REQ-014 out_valid  output  1  out_data is present.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 out_sat  output  1  out_data was saturated; qualified by out_valid.
REQ-017 coeff_wr_en / coeff_wr_addr / coeff_wr_data  input  1 / clog2(NUM_TAPS) / COEFF_W  shadow coefficient write port.
REQ-018 coeff_commit  input  1  copy shadow bank into active bank.

Function
REQ-019 A sample is accepted on a cycle with in_valid && in_ready.
REQ-020 in_ready SHALL be combinational: !out_valid || out_ready, forced 0 during rst and clear.
REQ-021 For accepted sample n: y[n] = sum over k=0..NUM_TAPS-1 of c[k]*x[n-k], with c = active bank and x[n-k] = the sample accepted k acceptances earlier.
REQ-022 Full-precision width W = DATA_W+COEFF_W+clog2(NUM_TAPS); no intermediate overflow.
REQ-023 Output conversion: if SHIFT>0, add 2^(SHIFT-1), then arithmetic shift right by SHIFT; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 iff clamped.
REQ-024 Warm-up: the first NUM_TAPS-1 accepted samples after reset/clear produce no output; counter saturates and never wraps.
REQ-025 Decimation: after warm-up, an output is produced for the first eligible sample and every DECIM-th accepted sample thereafter; phase counter wraps DECIM-1 -> 0.
REQ-026 Latency: out_valid rises on the cycle after the producing acceptance; out_data/out_sat registered.
REQ-027 out_valid, out_data, out_sat SHALL hold stable while out_valid && !out_ready.
REQ-028 out_valid clears after out_valid && out_ready unless a new output is produced on the same cycle.
REQ-029 Accepted samples not producing output (warm-up, decimation) SHALL still update history.
REQ-030 Shadow write: coeff_wr_addr >= NUM_TAPS ignored; writes never affect the active bank directly.
REQ-031 coeff_commit: active bank <= shadow bank contents as of the start of the cycle (a same-cycle write lands in shadow only).
REQ-032 Commit coinciding with an acceptance: that sample uses old coefficients; subsequent samples use new.
REQ-033 clear: zero history, warm-up counter, decimation phase, out_valid; coefficient banks unchanged; clear dominates same-cycle in_valid.

Reset
REQ-034 On rst: history zero, warm-up and phase counters 0, out_valid 0, out_data 0, out_sat 0.
REQ-035 On rst: active and shadow banks = unit impulse (c[0]=1, others 0); rst mid-stream discards any pending output.

Verification
REQ-036 Defaults, post-reset coefficients: feed 1..20 back-to-back, out_ready=1 -> no output for samples 1..14; outputs 15..20, each one cycle after acceptance.
REQ-037 Write all 15 coefficients =1, commit, feed constant 3 -> after 14 suppressed samples every output = 45; a write without commit leaves outputs unchanged.
REQ-038 DECIM=3, impulse coefficients, feed 1..30 -> outputs 15,18,21,24,27,30 only.
REQ-039 OUT_W=16, all coeffs 127, constant 32767 -> out_data 32767, out_sat=1; constant -32768 -> out_data -32768, out_sat=1; SHIFT=2, sum 6 -> out_data 2 (round half up).
REQ-040 out_ready low 5 cycles with in_valid held high -> in_ready 0 while out_valid, out_data unchanged, no sample dropped or duplicated when released.
REQ-041 Assert clear after 20 samples -> out_valid 0 next cycle, next 14 samples produce no output, coefficients retained; rst mid-stream -> impulse response restored.
